// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared definitions for the IF-stage fetch sequencer:
//            FSM state encodings, default NOP/HALT encodings, reset PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_incr.sv
// ============================================================================
// Module   : fetch_sequencer_incr
// Purpose  : Word-address PC incrementer (pc + 1, modulo 2^32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer_incr (
    input  logic [31:0] pc,
    output logic [31:0] pc_plus1
);

    // Wraps silently from 32'hFFFF_FFFF to 0
    assign pc_plus1 = pc + 32'd1;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : IF-stage fetch sequencer. Owns the PC, chooses the next PC
//            (increment / branch target / hold) and loads the IF/ID latch.
//            Optional performance counters enabled by FETCH_PERF_CNT_EN;
//            when undefined, fetch_count/bubble_count are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    fetch_state_t state;
    logic [31:0]  pc_plus1;
    logic         latch_fetch;
    logic         latch_bubble;

    fetch_sequencer_incr u_incr (
        .pc       (pc_out),
        .pc_plus1 (pc_plus1)
    );

    // Which kind of IF/ID load happens on the coming edge (a RUN-state stall loads neither)
    assign latch_fetch  = (state == RUN) && !branch_taken && !stall;
    assign latch_bubble = (state != RUN) || branch_taken;

    // Fetch FSM: PC, IF/ID latch and halt flag, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_out     <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_npc   <= 32'd0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    // imem gets one full cycle at RESET_PC before first fetch
                    ifid_instr <= NOP_INSTR;
                    ifid_npc   <= 32'd0;
                    ifid_valid <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    if (branch_taken) begin
                        // Squashed instruction is dead, so stall is irrelevant
                        pc_out     <= branch_target;
                        ifid_instr <= NOP_INSTR;
                        ifid_npc   <= 32'd0;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr <= instr_in;
                        ifid_npc   <= pc_plus1;
                        ifid_valid <= 1'b1;
                        if (instr_in == HALT_INSTR) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc_out <= pc_plus1;
                        end
                    end
                end
                HALT: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_npc   <= 32'd0;
                    ifid_valid <= 1'b0;
                    // An older branch still in flight may resume fetch
                    if (branch_taken) begin
                        pc_out <= branch_target;
                        halted <= 1'b0;
                        state  <= RUN;
                    end
                end
                default: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_npc   <= 32'd0;
                    ifid_valid <= 1'b0;
                    halted     <= 1'b0;
                    state      <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count valid fetches and bubbles as they are latched into IF/ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (latch_fetch)
                fetch_count <= fetch_count + 32'd1;
            if (latch_bubble)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`else
    assign fetch_count  = 32'd0;
    assign bubble_count = 32'd0;

    logic unused_latch;
    assign unused_latch = latch_fetch ^ latch_bubble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer: directed scenarios
//            followed by randomized stimulus against a behavioural model.
//            Honours FETCH_PERF_CNT_EN for counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the fetch stage
    logic [31:0] m_pc, m_instr, m_npc, m_fcnt, m_bcnt;
    logic        m_valid, m_halted, m_first_edge;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .ifid_instr    (ifid_instr),
        .ifid_npc      (ifid_npc),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = NOP_WORD; m_npc = 32'd0; m_valid = 1'b0;
        m_halted = 1'b0; m_first_edge = 1'b1; m_fcnt = 32'd0; m_bcnt = 32'd0;
    endtask

    task automatic model_bubble();
        m_instr = NOP_WORD; m_npc = 32'd0; m_valid = 1'b0; m_bcnt = m_bcnt + 32'd1;
    endtask

    // One rising edge of the model, using the inputs present at that edge
    task automatic model_edge();
        if (m_first_edge) begin
            m_first_edge = 1'b0;
            model_bubble();
        end else if (m_halted) begin
            if (branch_taken) begin
                m_pc = branch_target;
                m_halted = 1'b0;
            end
            model_bubble();
        end else if (branch_taken) begin
            m_pc = branch_target;
            model_bubble();
        end else if (!stall) begin
            m_instr = instr_in;
            m_npc   = m_pc + 32'd1;
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 32'd1;
            if (instr_in == HALT_WORD) m_halted = 1'b1;
            else                       m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_out, m_pc);
        chk({tag, ".instr"}, ifid_instr, m_instr);
        chk({tag, ".npc"},   ifid_npc, m_npc);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
        chk({tag, ".halt"},  {31'd0, halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".fcnt"},  fetch_count, m_fcnt);
        chk({tag, ".bcnt"},  bubble_count, m_bcnt);
`else
        chk({tag, ".fcnt"},  fetch_count, 32'd0);
        chk({tag, ".bcnt"},  bubble_count, 32'd0);
`endif
    endtask

    task automatic step(input string tag, input logic s, input logic b,
                        input logic [31:0] tgt, input logic [31:0] ins);
        stall = s; branch_taken = b; branch_target = tgt; instr_in = ins;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before the next edge
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; instr_in = 32'h0000_1111;
        model_reset();
        #3;
        check_all("reset");
        chk("reset_pc_const", pc_out, 32'd0);
        #1 rst = 1'b0;

        // BOOT then first fetch
        step("boot", 0, 0, 0, 32'h0000_1111);
        chk("boot_valid_const", {31'd0, ifid_valid}, 32'd0);
        step("fetch1", 0, 0, 0, 32'h0000_1111);
        chk("fetch1_npc_const", ifid_npc, 32'd1);
        step("run2", 0, 0, 0, 32'h0000_2222);
        step("run3", 0, 0, 0, 32'h0000_3333);
        step("stall1", 1, 0, 0, 32'hDEAD_0001);
        step("stall2", 1, 0, 0, 32'hDEAD_0002);
        chk("stall_pc_const", pc_out, 32'd3);
        step("unstall", 0, 0, 0, 32'h0000_4444);
        chk("unstall_pc_const", pc_out, 32'd4);
        step("run5", 0, 0, 0, 32'h0000_5555);

        // Branch wins over stall
        step("br_stall", 1, 1, 32'h40, 32'hBAD0_BAD0);
        chk("br_pc_const", pc_out, 32'h40);
        step("br_first", 0, 0, 0, 32'h0000_6666);
        chk("br_npc_const", ifid_npc, 32'h41);

        // HALT at pc=7, stall ignored while halted, branch resumes
        step("to7", 0, 1, 32'h7, 32'd0);
        step("halt_latch", 0, 0, 0, HALT_WORD);
        chk("halt_pc_const", pc_out, 32'h7);
        step("halt_bub", 1, 0, 0, 32'h1234_5678);
        step("halt_bub2", 0, 0, 0, 32'h1234_5678);
        step("halt_exit", 0, 1, 32'h10, 32'd0);
        chk("halt_exit_pc_const", pc_out, 32'h10);

        // PC wraparound
        step("to_max", 0, 1, 32'hFFFF_FFFF, 32'd0);
        step("wrap", 0, 0, 0, 32'h0000_7777);
        chk("wrap_pc_const", pc_out, 32'd0);
        chk("wrap_npc_const", ifid_npc, 32'd0);

        // Async reset mid-cycle, then counter scenario
        async_reset("async_rst");
        step("cnt_boot", 0, 0, 0, 32'h1);
        for (int i = 0; i < 4; i++) step("cnt_run", 0, 0, 0, 32'h100 + i);
        step("cnt_redir", 0, 1, 32'h80, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count_const", fetch_count, 32'd4);
        chk("bubble_count_const", bubble_count, 32'd2);
`else
        chk("fetch_count_const", fetch_count, 32'd0);
        chk("bubble_count_const", bubble_count, 32'd0);
`endif

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            logic        r_s, r_b;
            logic [31:0] r_t, r_i;
            r_s = ($urandom_range(0, 3) == 0);
            r_b = ($urandom_range(0, 9) == 0);
            r_t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            r_i = ($urandom_range(0, 19) == 0) ? HALT_WORD : $urandom;
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
            else step("rand", r_s, r_b, r_t, r_i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
